// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
// Consumers use fifo_addr_w() to size threshold and level buses.
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 32;

  // Pointer width for a given depth; threshold/level buses are one bit wider.
  function automatic int fifo_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Error flag pair carried as one register.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a registered read port.
// The array itself is not reset; only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DATA_W = FIFO_DATA_W_DEF,
  parameter  int DEPTH  = FIFO_DEPTH_DEF,
  localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage write; contents survive reset and are simply overwritten later.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register loads only on an accepted read, otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Read data register with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with occupancy flags, programmable
// almost-full/almost-empty thresholds and overflow/underflow reporting.
// Optional macro FIFO_ERR_STICKY_EN makes the error flags sticky until
// err_clr; without it they are one-cycle pulses and err_clr is ignored.
module fifo_buffer_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W = FIFO_DATA_W_DEF,
  parameter  int DEPTH  = FIFO_DEPTH_DEF,
  localparam int ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   full_thres,
  input  logic [ADDR_W:0]   empty_thres,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  fifo_err_t         err_q, err_d, err_evt;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags come straight from the registered count so they never lag.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == DEPTH_CNT);
    almost_full  = (count_q >= full_thres);
    almost_empty = (count_q <= empty_thres);
    level        = count_q;
  end

  // Accept logic: a read frees a slot on the same edge, so a full FIFO
  // still takes a write when a read is also accepted.
  always_comb begin
    rd_acc = read_enable && !empty;
    wr_acc = write_enable && (!full || rd_acc);
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Error detection and flag next-state (pulse or sticky).
  always_comb begin
    err_evt.overflow  = write_enable && full && !rd_acc;
    err_evt.underflow = read_enable && empty;
`ifdef FIFO_ERR_STICKY_EN
    err_d.overflow  = err_evt.overflow  | (err_q.overflow  & ~err_clr);
    err_d.underflow = err_evt.underflow | (err_q.underflow & ~err_clr);
`else
    err_d = err_evt;
`endif
  end

`ifndef FIFO_ERR_STICKY_EN
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
`endif

  // Control state registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (wr_acc),
    .waddr   (wr_ptr_q),
    .wdata   (data_in),
    .re      (rd_acc),
    .raddr   (rd_ptr_q),
    .rdata   (data_out)
  );

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Directed self-checking bench for fifo_buffer_param (DATA_W=8, DEPTH=32).
// Build with FIFO_ERR_STICKY_EN defined to exercise the sticky error flags.
module tb_fifo_buffer_param;

  logic       clock;
  logic       reset_n;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_in;
  logic [5:0] full_thres;
  logic [5:0] empty_thres;
  logic       err_clr;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic [5:0] level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_buffer_param #(
    .DATA_W (8),
    .DEPTH  (32)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_in      (data_in),
    .full_thres   (full_thres),
    .empty_thres  (empty_thres),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one cycle of requests, then settle just after the active edge.
  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] din);
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    @(posedge clock);
    #1;
  endtask

  // Compare one observed value against its hand-derived expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int         wr_idx;
    int         rd_idx;
    int         ft;
    logic [7:0] exp_byte;

    reset_n      = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = 8'h00;
    full_thres   = 6'd32;
    empty_thres  = 6'd2;
    err_clr      = 1'b0;
    #12;

    $display("[TB] reset state");
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_almost_empty", almost_empty, 1);
    checkOutput("rst_almost_full", almost_full, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_underflow", underflow, 0);
    reset_n = 1'b1;

    $display("[TB] fill 0..31");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      checkOutput("fill_level", level, i + 1);
      checkOutput("fill_almost_empty", almost_empty, (i + 1 <= 2) ? 1 : 0);
      checkOutput("fill_almost_full", almost_full, (i + 1 >= 32) ? 1 : 0);
      checkOutput("fill_full", full, (i + 1 == 32) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b0, 8'd99);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_level", level, 32);

`ifdef FIFO_ERR_STICKY_EN
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      checkOutput("ovf_sticky_hold", overflow, 1);
    end
    err_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("ovf_sticky_clr", overflow, 0);
    applyStimulus(1'b1, 1'b0, 8'd98);
    checkOutput("ovf_set_beats_clr", overflow, 1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("ovf_sticky_clr2", overflow, 0);
    err_clr = 1'b0;
`else
    applyStimulus(1'b0, 1'b0, 8'd0);
    checkOutput("ovf_pulse_end", overflow, 0);
`endif
    checkOutput("ovf_level_kept", level, 32);

    $display("[TB] drain 32 words");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 8'd0);
      checkOutput("drain_data", data_out, i);
      checkOutput("drain_level", level, 31 - i);
    end
    checkOutput("drain_empty", empty, 1);
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("udf_set", underflow, 1);
    checkOutput("udf_data_hold", data_out, 31);
    checkOutput("udf_level", level, 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
`ifdef FIFO_ERR_STICKY_EN
    checkOutput("udf_sticky_hold", underflow, 1);
    err_clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    err_clr = 1'b0;
`endif
    checkOutput("udf_cleared", underflow, 0);

    $display("[TB] simultaneous read/write at empty and full");
    applyStimulus(1'b1, 1'b1, 8'd64);
    checkOutput("rw_empty_level", level, 1);
    checkOutput("rw_empty_udf", underflow, 1);
    checkOutput("rw_empty_no_bypass", data_out, 31);
    checkOutput("rw_empty_not_empty", empty, 0);
    err_clr = 1'b1;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(64 + i));
      checkOutput("refill_level", level, i + 1);
    end
    err_clr = 1'b0;
    checkOutput("refill_full", full, 1);
    checkOutput("refill_udf_gone", underflow, 0);
    applyStimulus(1'b1, 1'b1, 8'd200);
    checkOutput("rw_full_level", level, 32);
    checkOutput("rw_full_no_ovf", overflow, 0);
    checkOutput("rw_full_data", data_out, 64);
    applyStimulus(1'b1, 1'b1, 8'd201);
    checkOutput("rw_full_data2", data_out, 65);
    checkOutput("rw_full_level2", level, 32);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 8'd0);
      exp_byte = (i < 30) ? 8'(66 + i) : ((i == 30) ? 8'd200 : 8'd201);
      checkOutput("rw_drain_data", data_out, exp_byte);
      checkOutput("rw_drain_level", level, 31 - i);
    end

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd5);
    end
    write_enable = 1'b0;
    checkOutput("pre_rst_level", level, 3);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_empty", empty, 1);
    checkOutput("mid_rst_data_out", data_out, 0);
    #2;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'd0);
    checkOutput("post_rst_data", data_out, 8'h5A);
    checkOutput("post_rst_level", level, 0);

    $display("[TB] pointer wrap with threshold change");
    wr_idx = 0;
    rd_idx = 0;
    ft     = 32;
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 5; j++) begin
        applyStimulus(1'b1, 1'b0, 8'(wr_idx * 7 + 3));
        wr_idx++;
        checkOutput("wrap_wr_level", level, j + 1);
        checkOutput("wrap_wr_af", almost_full, (j + 1 >= ft) ? 1 : 0);
      end
      if (r == 10) begin
        full_thres = 6'd4;
        ft         = 4;
        #1;
        checkOutput("thres_change_af", almost_full, 1);
      end
      for (int j = 0; j < 5; j++) begin
        applyStimulus(1'b0, 1'b1, 8'd0);
        exp_byte = 8'(rd_idx * 7 + 3);
        rd_idx++;
        checkOutput("wrap_rd_data", data_out, exp_byte);
        checkOutput("wrap_rd_level", level, 4 - j);
        checkOutput("wrap_rd_af", almost_full, (4 - j >= ft) ? 1 : 0);
      end
    end
    checkOutput("wrap_final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
